// File: rtl/useq_pkg.sv
// Shared encodings for the useq host bridge: FSM state and round-robin grant.
package useq_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_PULSE   = 3'd1,
        RD_PULSE   = 3'd2,
        RD_CAPTURE = 3'd3,
        GAP        = 3'd4
    } bridge_state_t;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } grant_t;

endpackage

// File: rtl/useq_byte_buf.sv
// Small circular byte buffer with simultaneous push/pop; head is always visible.
module useq_byte_buf #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    assign do_pop = pop & (count != '0);
    assign head   = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/useq_host_bridge.sv
// Host-side adapter for the useq message FIFO: rate-limited, mutually exclusive
// write/read pulses with round-robin arbitration and a small output buffer.
module useq_host_bridge
    import useq_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned OUT_DEPTH  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       write_fifo,
    output logic       read_fifo,
    output logic [7:0] fifo_in,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_out
);

    localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    bridge_state_t state;
    grant_t        rr_last;
    logic [GW-1:0] gap_cnt;
    logic [CW-1:0] buf_count;
    logic          wr_cand;
    logic          rd_cand;
    logic          gnt_wr;
    logic          gnt_rd;
    logic          cap_push;
    logic          host_pop;

    // Space is reserved at grant: with one read in flight, count < depth here
    // guarantees the later capture fits.
    always_comb begin
        wr_cand = in_valid & ~fifo_full;
        rd_cand = ~fifo_empty & (buf_count < CW'(OUT_DEPTH));
        gnt_wr  = 1'b0;
        gnt_rd  = 1'b0;
        if (rst_n && state == IDLE) begin
            if (wr_cand && rd_cand) begin
                gnt_wr = (rr_last == READ);
                gnt_rd = (rr_last == WRITE);
            end else begin
                gnt_wr = wr_cand;
                gnt_rd = rd_cand;
            end
        end
    end

    assign in_ready  = gnt_wr;
    assign out_valid = (buf_count != '0);
    assign host_pop  = out_valid & out_ready;
    assign cap_push  = (state == RD_CAPTURE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_last    <= READ;
            gap_cnt    <= '0;
            write_fifo <= 1'b0;
            read_fifo  <= 1'b0;
            fifo_in    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_wr) begin
                        fifo_in    <= in_data;
                        write_fifo <= 1'b1;
                        rr_last    <= WRITE;
                        state      <= WR_PULSE;
                    end else if (gnt_rd) begin
                        read_fifo <= 1'b1;
                        rr_last   <= READ;
                        state     <= RD_PULSE;
                    end
                end
                WR_PULSE: begin
                    write_fifo <= 1'b0;
                    state      <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
                RD_PULSE: begin
                    read_fifo <= 1'b0;
                    state     <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    state <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
                GAP: begin
                    if (32'(gap_cnt) >= GAP_CYCLES - 1) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    useq_byte_buf #(
        .DEPTH (OUT_DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap_push),
        .push_data (fifo_out),
        .pop       (host_pop),
        .head      (out_data),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_useq_host_bridge.sv
// Self-checking bench for useq_host_bridge: grant table, directed corner cases,
// and randomized loopback through a 16-deep core FIFO model.
module tb_useq_host_bridge;

    localparam int GAP        = 1;
    localparam int DEPTH      = 2;
    localparam int CORE_DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       write_fifo;
    logic       read_fifo;
    logic [7:0] fifo_in;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_out;

    // Bench knobs: direct flag drive, forced-empty view, preload port.
    logic       flag_mode = 1'b0;
    logic       tb_full = 1'b0;
    logic       tb_empty = 1'b1;
    logic [7:0] tb_fout = 8'h00;
    logic       force_empty = 1'b0;
    logic       core_rst = 1'b1;
    logic       pre_en = 1'b0;
    logic [7:0] pre_data = 8'h00;

    // Core FIFO model
    logic [7:0] core_mem [CORE_DEPTH];
    int         core_cnt = 0;
    int         core_wp = 0;
    int         core_rp = 0;
    logic [7:0] core_dout = 8'h00;
    logic       core_push;
    logic       core_pop;

    always #5 clk = ~clk;

    useq_host_bridge #(
        .GAP_CYCLES (GAP),
        .OUT_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .write_fifo (write_fifo),
        .read_fifo  (read_fifo),
        .fifo_in    (fifo_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_out   (fifo_out)
    );

    assign core_push  = (write_fifo || pre_en) && (core_cnt < CORE_DEPTH);
    assign core_pop   = read_fifo && (core_cnt > 0);
    assign fifo_full  = flag_mode ? tb_full : (core_cnt == CORE_DEPTH);
    assign fifo_empty = flag_mode ? tb_empty : (force_empty || core_cnt == 0);
    assign fifo_out   = flag_mode ? tb_fout : core_dout;

    always @(posedge clk) begin
        if (core_rst) begin
            core_cnt  <= 0;
            core_wp   <= 0;
            core_rp   <= 0;
            core_dout <= 8'h00;
        end else begin
            if (core_push) begin
                core_mem[core_wp] <= pre_en ? pre_data : fifo_in;
                core_wp           <= (core_wp + 1) % CORE_DEPTH;
            end
            if (core_pop) begin
                core_dout <= core_mem[core_rp];
                core_rp   <= (core_rp + 1) % CORE_DEPTH;
            end
            core_cnt <= core_cnt + (core_push ? 1 : 0) - (core_pop ? 1 : 0);
        end
    end

    // Checking bookkeeping and reference model state
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;
    bit         host_feed = 1'b0;
    bit         valid_rand = 1'b0;
    logic [7:0] host_q [$];
    logic [7:0] acc_q [$];
    logic [7:0] exp_out [$];
    logic [7:0] popped [$];
    bit         kinds [$];
    int         pulse_cyc [$];
    bit         p1_v, p2_v;
    logic [7:0] p1_d, p2_d;
    bit         prev_pulse;
    bit         last_rd;
    int         last_pulse;
    int         cyc_n = 0;
    int         wr_pulses, rd_pulses;
    int         first_rd_cyc, first_ov_cyc;
    int         sent = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic clear_model();
        acc_q.delete();
        exp_out.delete();
        popped.delete();
        kinds.delete();
        pulse_cyc.delete();
        p1_v = 1'b0;
        p2_v = 1'b0;
        prev_pulse = 1'b0;
        last_rd = 1'b0;
        last_pulse = -100;
        wr_pulses = 0;
        rd_pulses = 0;
        first_rd_cyc = -1;
        first_ov_cyc = -1;
    endtask

    // Transaction-level reference: bytes accepted from the host must be written
    // in order; bytes read from the core appear at the output two cycles later.
    task automatic monitor();
        if (mon_en) begin
            check_eq("pulse_overlap", int'(write_fifo & read_fifo), 0);
            if (write_fifo || read_fifo) begin
                check_eq("back_to_back_pulse", int'(prev_pulse), 0);
                check_eq("pulse_spacing_ok",
                         int'((cyc_n - last_pulse) >= (last_rd ? 3 + GAP : 2 + GAP)), 1);
                last_pulse = cyc_n;
                last_rd    = read_fifo;
                kinds.push_back(read_fifo);
                pulse_cyc.push_back(cyc_n);
            end
            if (write_fifo) begin
                wr_pulses++;
                check_eq("write_into_full_core", int'(core_cnt < CORE_DEPTH), 1);
                check_eq("write_has_source", acc_q.size(), 1);
                if (acc_q.size() != 0) begin
                    check_eq("write_data", int'(fifo_in), int'(acc_q.pop_front()));
                end
            end
            if (read_fifo) begin
                rd_pulses++;
                check_eq("read_while_empty", int'(fifo_empty), 0);
                if (first_rd_cyc < 0) first_rd_cyc = cyc_n;
            end
            if (p2_v) begin
                exp_out.push_back(p2_d);
                check_eq("capture_fits_buffer", int'(exp_out.size() <= DEPTH), 1);
            end
            p2_v = p1_v;
            p2_d = p1_d;
            p1_v = read_fifo;
            p1_d = core_mem[core_rp];
            check_eq("out_valid", int'(out_valid), int'(exp_out.size() != 0));
            if (out_valid && exp_out.size() != 0) begin
                check_eq("out_data", int'(out_data), int'(exp_out[0]));
            end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc_n;
            check_eq("in_ready_legal", int'(in_ready & ~(in_valid & ~fifo_full)), 0);
            if (in_valid && in_ready) acc_q.push_back(in_data);
            if (out_valid && out_ready && exp_out.size() != 0) popped.push_back(exp_out.pop_front());
            prev_pulse = write_fifo | read_fifo;
        end
        cyc_n++;
    endtask

    task automatic cyc();
        bit acc;
        if (host_feed) begin
            in_valid = (host_q.size() != 0) && (!valid_rand || $urandom_range(3) != 0);
            in_data  = in_valid ? host_q[0] : 8'($urandom);
        end
        @(negedge clk);
        acc = in_valid & in_ready;
        monitor();
        if (host_feed && acc && host_q.size() != 0) void'(host_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en      = 1'b0;
        host_feed   = 1'b0;
        valid_rand  = 1'b0;
        rst_n       = 1'b0;
        core_rst    = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        pre_en      = 1'b0;
        force_empty = 1'b0;
        flag_mode   = 1'b0;
        host_q.delete();
        cyc();
        cyc();
        rst_n    = 1'b1;
        core_rst = 1'b0;
        clear_model();
        mon_en = 1'b1;
    endtask

    task automatic preload(input logic [7:0] b);
        pre_en   = 1'b1;
        pre_data = b;
        cyc();
        pre_en = 1'b0;
    endtask

    task automatic drain(input int budget, input string tag);
        valid_rand  = 1'b0;
        out_ready   = 1'b1;
        force_empty = 1'b0;
        repeat (budget) cyc();
        check_eq({tag, "_host_q_empty"}, host_q.size(), 0);
        check_eq({tag, "_exp_out_empty"}, exp_out.size(), 0);
        check_eq({tag, "_core_empty"}, core_cnt, 0);
        check_eq({tag, "_out_valid_low"}, int'(out_valid), 0);
    endtask

    typedef struct {
        logic iv;
        logic full;
        logic empty;
        logic exp_ready;
        logic exp_wr;
        logic exp_rd;
    } grant_vec_t;

    grant_vec_t gv [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;

        // IDLE grant decision from a fresh reset (rr_last=READ, buffer empty)
        gv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        gv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        gv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        gv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        gv[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        gv[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        gv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        gv[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset values
        do_reset();
        @(negedge clk);
        check_eq("rst_in_ready", int'(in_ready), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_data", int'(out_data), 0);
        check_eq("rst_write_fifo", int'(write_fifo), 0);
        check_eq("rst_read_fifo", int'(read_fifo), 0);
        check_eq("rst_fifo_in", int'(fifo_in), 0);
        @(posedge clk);
        #1;

        // Grant table with directly driven core flags
        for (int i = 0; i < 8; i++) begin
            do_reset();
            mon_en    = 1'b0;
            flag_mode = 1'b1;
            tb_fout   = 8'hC3;
            in_valid  = gv[i].iv;
            in_data   = 8'(8'h40 + i);
            tb_full   = gv[i].full;
            tb_empty  = gv[i].empty;
            @(negedge clk);
            check_eq($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(gv[i].exp_ready));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            tb_empty = 1'b1;
            @(negedge clk);
            check_eq($sformatf("tbl%0d_write_fifo", i), int'(write_fifo), int'(gv[i].exp_wr));
            check_eq($sformatf("tbl%0d_read_fifo", i), int'(read_fifo), int'(gv[i].exp_rd));
            check_eq($sformatf("tbl%0d_fifo_in", i), int'(fifo_in), gv[i].exp_wr ? 8'h40 + i : 0);
            @(posedge clk);
            #1;
        end

        // Write path: pulses exactly every 2+GAP cycles
        do_reset();
        force_empty = 1'b1;
        host_q = '{8'h11, 8'h22, 8'h33};
        host_feed = 1'b1;
        repeat (12) cyc();
        check_eq("wr_path_pulses", wr_pulses, 3);
        if (pulse_cyc.size() == 3) begin
            check_eq("wr_path_gap1", pulse_cyc[1] - pulse_cyc[0], 2 + GAP);
            check_eq("wr_path_gap2", pulse_cyc[2] - pulse_cyc[1], 2 + GAP);
        end
        check_eq("wr_path_core_cnt", core_cnt, 3);
        check_eq("wr_path_b0", int'(core_mem[0]), 8'h11);
        check_eq("wr_path_b1", int'(core_mem[1]), 8'h22);
        check_eq("wr_path_b2", int'(core_mem[2]), 8'h33);

        // Full core FIFO: 17th byte held until a read frees a slot
        do_reset();
        force_empty = 1'b1;
        for (int i = 0; i < 17; i++) host_q.push_back(8'(i * 7 + 1));
        host_feed = 1'b1;
        repeat (60) cyc();
        check_eq("full_pulses", wr_pulses, 16);
        check_eq("full_core_cnt", core_cnt, CORE_DEPTH);
        check_eq("full_byte_held", host_q.size(), 1);
        check_eq("full_in_ready_low", int'(in_ready), 0);
        force_empty = 1'b0;
        out_ready   = 1'b1;
        for (int i = 0; i < 40 && wr_pulses < 17; i++) cyc();
        check_eq("full_17th_written", wr_pulses, 17);
        check_eq("full_read_first", int'(rd_pulses >= 1), 1);
        drain(150, "full");

        // Read path with latency
        do_reset();
        force_empty = 1'b1;
        preload(8'hA5);
        preload(8'h5A);
        out_ready   = 1'b1;
        force_empty = 1'b0;
        repeat (20) cyc();
        check_eq("rd_path_pulses", rd_pulses, 2);
        check_eq("rd_path_count", popped.size(), 2);
        if (popped.size() == 2) begin
            check_eq("rd_path_b0", int'(popped[0]), 8'hA5);
            check_eq("rd_path_b1", int'(popped[1]), 8'h5A);
        end
        check_eq("rd_path_latency", first_ov_cyc - first_rd_cyc, 2);

        // Contention alternates starting with WRITE
        do_reset();
        force_empty = 1'b1;
        for (int i = 1; i <= 4; i++) preload(8'(i));
        for (int i = 0; i < 8; i++) host_q.push_back(8'(8'hB0 + i));
        out_ready   = 1'b1;
        host_feed   = 1'b1;
        force_empty = 1'b0;
        repeat (30) cyc();
        check_eq("contend_pulse_count", int'(kinds.size() >= 6), 1);
        if (kinds.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check_eq($sformatf("contend_kind%0d", i), int'(kinds[i]), i % 2);
            end
        end
        drain(150, "contend");

        // Backpressure with a full output buffer
        do_reset();
        force_empty = 1'b1;
        for (int i = 0; i < 5; i++) preload(8'(8'h61 + i));
        out_ready   = 1'b0;
        force_empty = 1'b0;
        repeat (30) cyc();
        check_eq("bp_reads_withheld", rd_pulses, 2);
        check_eq("bp_core_cnt", core_cnt, 3);
        drain(60, "bp");
        check_eq("bp_total_reads", rd_pulses, 5);
        check_eq("bp_popped", popped.size(), 5);
        for (int i = 0; i < 5 && i < popped.size(); i++) begin
            check_eq($sformatf("bp_byte%0d", i), int'(popped[i]), 8'h61 + i);
        end

        // Reset asserted during a read pulse
        do_reset();
        force_empty = 1'b1;
        preload(8'hA5);
        preload(8'h5A);
        out_ready   = 1'b1;
        force_empty = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            found = read_fifo;
        end
        check_eq("rst_mid_found_rd_pulse", int'(found), 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_mid_write_fifo", int'(write_fifo), 0);
        check_eq("rst_mid_read_fifo", int'(read_fifo), 0);
        check_eq("rst_mid_fifo_in", int'(fifo_in), 0);
        check_eq("rst_mid_out_valid", int'(out_valid), 0);
        check_eq("rst_mid_out_data", int'(out_data), 0);
        check_eq("rst_mid_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        mon_en = 1'b1;
        repeat (20) cyc();
        check_eq("rst_mid_wr_pulses", wr_pulses, 0);
        check_eq("rst_mid_rd_pulses", rd_pulses, 1);
        check_eq("rst_mid_popped", popped.size(), 1);
        if (popped.size() == 1) check_eq("rst_mid_byte", int'(popped[0]), 8'h5A);

        // Randomized loopback: host -> core -> host
        do_reset();
        host_feed  = 1'b1;
        valid_rand = 1'b1;
        sent = 0;
        for (int i = 0; i < 1500; i++) begin
            if (host_q.size() < 4 && $urandom_range(2) == 0) begin
                host_q.push_back(8'($urandom));
                sent++;
            end
            if ((i / 200) % 2 == 1) out_ready = ($urandom_range(7) == 0);
            else                    out_ready = ($urandom_range(3) != 0);
            cyc();
        end
        drain(200, "rand");
        check_eq("rand_all_delivered", popped.size(), sent);
        check_eq("rand_all_written", wr_pulses, sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
